// File: rtl/cdc_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : cdc_pulse_gen
// Description : Programmable pulse-train source for exercising a destination
//               domain glitch monitor. Generates C pulses of W cycles spaced
//               by G idle cycles around a selectable idle level, and marks
//               pulses narrower than MIN_HOLD source cycles as "short".
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_pulse_gen #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MIN_HOLD = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             level_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic [CNT_W-1:0] gap_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             d_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             short_o,
  output logic [CNT_W-1:0] pulse_cnt_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  // State and datapath registers
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] r_count;
  logic             r_level;
  logic             r_short_w;

  // Registered outputs
  logic             r_d;
  logic             r_busy;
  logic             r_done;
  logic             r_short;

  // Next-state and next-output values
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_pcnt_nxt;
  logic             w_accept;
  logic [CNT_W-1:0] w_width_in;
  logic [CNT_W-1:0] w_gap_in;
  logic             w_level_nxt;
  logic             w_short_w_nxt;
  logic             w_d_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_short_nxt;

  // Zero width/gap are clamped to one so every pulse and every gap is visible
  assign w_width_in = (width_i == '0) ? C_ONE : width_i;
  assign w_gap_in   = (gap_i   == '0) ? C_ONE : gap_i;

  // The level and short flag that will be in force in the next cycle
  assign w_level_nxt   = w_accept ? level_i : r_level;
  assign w_short_w_nxt = w_accept ? (32'(w_width_in) < MIN_HOLD) : r_short_w;

  // State, counters, latched parameters and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pcnt    <= '0;
      r_width   <= C_ONE;
      r_gap     <= C_ONE;
      r_count   <= '0;
      r_level   <= 1'b0;
      r_short_w <= 1'b0;
      r_d       <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_short   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pcnt    <= w_pcnt_nxt;
      r_level   <= w_level_nxt;
      r_short_w <= w_short_w_nxt;
      if (w_accept) begin
        r_width <= w_width_in;
        r_gap   <= w_gap_in;
        r_count <= count_i;
      end
      r_d       <= w_d_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_short   <= w_short_nxt;
    end
  end

  // Next-state logic: one down-counter times both pulse and gap phases
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pcnt_nxt  = r_pcnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_accept   = 1'b1;
          w_pcnt_nxt = '0;
          if (count_i != '0) begin
            w_state_nxt = S_PULSE;
            w_cnt_nxt   = w_width_in - C_ONE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_PULSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = r_gap - C_ONE;
          w_pcnt_nxt  = r_pcnt + C_ONE;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          if (r_pcnt < r_count) begin
            w_state_nxt = S_PULSE;
            w_cnt_nxt   = r_width - C_ONE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Abort overrides everything outside IDLE; completed-pulse count is kept
    if (abort_i && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = r_cnt;
      w_pcnt_nxt  = r_pcnt;
    end
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    w_d_nxt     = w_level_nxt;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_short_nxt = 1'b0;
    case (w_state_nxt)
      S_PULSE: begin
        w_d_nxt     = ~w_level_nxt;
        w_busy_nxt  = 1'b1;
        w_short_nxt = w_short_w_nxt;
      end
      S_GAP: begin
        w_busy_nxt = 1'b1;
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
        w_d_nxt = w_level_nxt;
      end
    endcase
  end

  assign d_o         = r_d;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign short_o     = r_short;
  assign pulse_cnt_o = r_pcnt;

endmodule
`default_nettype wire

// File: tb/tb_cdc_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_pulse_gen
// Description : Directed self-checking bench for cdc_pulse_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_pulse_gen;

  localparam int CNT_W    = 8;
  localparam int MIN_HOLD = 2;

  logic             clk_i   = 1'b0;
  logic             rstn_i  = 1'b0;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic             level_i = 1'b0;
  logic [CNT_W-1:0] width_i = '0;
  logic [CNT_W-1:0] gap_i   = '0;
  logic [CNT_W-1:0] count_i = '0;
  logic             d_o;
  logic             busy_o;
  logic             done_o;
  logic             short_o;
  logic [CNT_W-1:0] pulse_cnt_o;

  int n_cmp = 0;
  int n_mis = 0;

  cdc_pulse_gen #(
    .CNT_W    (CNT_W),
    .MIN_HOLD (MIN_HOLD)
  ) u_dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .level_i     (level_i),
    .width_i     (width_i),
    .gap_i       (gap_i),
    .count_i     (count_i),
    .d_o         (d_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .short_o     (short_o),
    .pulse_cnt_o (pulse_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected d_o on cycle N+k for a train with clamped width w and gap g
  function automatic logic exp_d(int k, logic lvl, int w, int g, int c);
    int idx;
    idx = k - 1;
    if (idx >= 0 && idx < c * (w + g) && (idx % (w + g)) < w) return ~lvl;
    return lvl;
  endfunction

  // Pulses completed and visible on cycle N+k
  function automatic int exp_p(int k, int w, int g, int c);
    int n;
    n = 0;
    for (int j = 0; j < c; j++)
      if (j * (w + g) + w + 1 <= k) n++;
    return n;
  endfunction

  // Present a start request; returns just after edge N
  task automatic launch(input logic lvl, input int w, input int g, input int c,
                        input bit hold, input bit ab);
    @(negedge clk_i);
    level_i = lvl;
    width_i = CNT_W'(w);
    gap_i   = CNT_W'(g);
    count_i = CNT_W'(c);
    start_i = 1'b1;
    abort_i = ab;
    @(posedge clk_i);
    #1;
    if (!hold) start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  // Run a whole train and compare every output on every cycle to the timing formula
  task automatic run_train(input string name, input logic lvl, input int w_raw,
                           input int g_raw, input int c, input bit hold, input bit ab);
    int w, g, d;
    logic ed;
    w = (w_raw == 0) ? 1 : w_raw;
    g = (g_raw == 0) ? 1 : g_raw;
    d = c * (w + g) + 1;
    launch(lvl, w_raw, g_raw, c, hold, ab);
    for (int k = 1; k <= d + 1; k++) begin
      @(negedge clk_i);
      ed = exp_d(k, lvl, w, g, c);
      check($sformatf("%s d_o@%0d", name, k), 32'(d_o), 32'(ed));
      check($sformatf("%s busy@%0d", name, k), 32'(busy_o), 32'(k <= c * (w + g)));
      check($sformatf("%s done@%0d", name, k), 32'(done_o), 32'(k == d));
      check($sformatf("%s short@%0d", name, k), 32'(short_o),
            32'((ed != lvl) && (w < MIN_HOLD)));
      check($sformatf("%s pcnt@%0d", name, k), 32'(pulse_cnt_o), 32'(exp_p(k, w, g, c)));
      if (k == d + 1) start_i = 1'b0;
    end
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst d_o", 32'(d_o), 32'd0);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst done", 32'(done_o), 32'd0);
    check("rst short", 32'(short_o), 32'd0);
    check("rst pcnt", 32'(pulse_cnt_o), 32'd0);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

    run_train("basic", 1'b0, 3, 2, 4, 1'b0, 1'b0);
    run_train("short", 1'b0, 1, 0, 3, 1'b0, 1'b0);
    run_train("inv", 1'b1, 2, 1, 2, 1'b0, 1'b0);
    run_train("cnt0", 1'b0, 3, 2, 0, 1'b0, 1'b0);
    run_train("wclamp", 1'b0, 0, 2, 2, 1'b0, 1'b0);
    run_train("st_ab", 1'b0, 1, 1, 1, 1'b0, 1'b1);
    run_train("hold", 1'b0, 2, 2, 2, 1'b1, 1'b0);

    // Abort during the second pulse of a W=4 G=4 C=5 train
    launch(1'b0, 4, 4, 5, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      check($sformatf("abort d_o@%0d", k), 32'(d_o), 32'(exp_d(k, 1'b0, 4, 4, 5)));
      check($sformatf("abort pcnt@%0d", k), 32'(pulse_cnt_o), 32'(exp_p(k, 4, 4, 5)));
    end
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("abort d_o", 32'(d_o), 32'd0);
    check("abort busy", 32'(busy_o), 32'd0);
    check("abort done", 32'(done_o), 32'd0);
    check("abort pcnt", 32'(pulse_cnt_o), 32'd1);
    for (int k = 12; k <= 15; k++) begin
      @(negedge clk_i);
      check($sformatf("abort idle done@%0d", k), 32'(done_o), 32'd0);
      check($sformatf("abort idle busy@%0d", k), 32'(busy_o), 32'd0);
      check($sformatf("abort idle d_o@%0d", k), 32'(d_o), 32'd0);
    end

    // Reset in the middle of an inverted-level pulse
    launch(1'b1, 2, 2, 2, 1'b0, 1'b0);
    @(negedge clk_i);
    check("mrst pulse d_o", 32'(d_o), 32'd0);
    rstn_i = 1'b0;
    @(negedge clk_i);
    check("mrst d_o", 32'(d_o), 32'd0);
    check("mrst busy", 32'(busy_o), 32'd0);
    check("mrst pcnt", 32'(pulse_cnt_o), 32'd0);
    check("mrst done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    check("mrst hold d_o", 32'(d_o), 32'd0);
    check("mrst hold pcnt", 32'(pulse_cnt_o), 32'd0);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("mrst idle d_o", 32'(d_o), 32'd0);
    check("mrst idle busy", 32'(busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
